scene_ctrl: RTL and testbench

SCENE_CTRL -- requirements
Module: scene_ctrl

---
 rtl/scene_pkg.sv | 18 +
 rtl/scene_ctrl_if.sv | 47 ++++
 rtl/clear_scan.sv | 49 ++++
 rtl/scene_ctrl.sv | 164 ++++++++++++++++
 tb/tb_scene_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scene_pkg.sv
// scene_pkg
// Shared definitions for the scene controller: the controller FSM state type
// and the default screen geometry and clear colour used by scene_ctrl.
// No ports (package).
package scene_pkg;

  localparam int         SCREEN_W_DEF     = 160;
  localparam int         SCREEN_H_DEF     = 120;
  localparam logic [2:0] CLEAR_COLOUR_DEF = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/scene_ctrl_if.sv
// scene_ctrl_if
// Groups the shape-drawer handshake and the VGA pixel write port.
//   master : scene controller side (drives drawer controls and VGA port,
//            receives drawer pixel stream)
//   slave  : drawer / VGA adapter side
// Signals:
//   shape_rst_n, shape_start          controller -> drawer control
//   shape_colour/centre_x/centre_y/
//   shape_diameter                    controller -> drawer captured parameters
//   shape_done, shape_x, shape_y,
//   shape_vga_colour, shape_plot      drawer -> controller pixel stream
//   vga_x, vga_y, vga_colour, vga_plot controller -> VGA adapter
interface scene_ctrl_if;

  logic       shape_rst_n;
  logic       shape_start;
  logic [2:0] shape_colour;
  logic [7:0] shape_centre_x;
  logic [6:0] shape_centre_y;
  logic [7:0] shape_diameter;

  logic       shape_done;
  logic [7:0] shape_x;
  logic [6:0] shape_y;
  logic [2:0] shape_vga_colour;
  logic       shape_plot;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output shape_rst_n, shape_start, shape_colour, shape_centre_x,
           shape_centre_y, shape_diameter,
    input  shape_done, shape_x, shape_y, shape_vga_colour, shape_plot,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  shape_rst_n, shape_start, shape_colour, shape_centre_x,
           shape_centre_y, shape_diameter,
    output shape_done, shape_x, shape_y, shape_vga_colour, shape_plot,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/clear_scan.sv
// clear_scan
// Column-major raster scan used for the full-screen clear: scan_y runs
// 0..H-1, and each time it wraps scan_x advances by one.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        zero both counters (start of a new clear)
//   en         advance the scan by one pixel
//   scan_x     current column
//   scan_y     current row
//   last       high while the scan sits on the final pixel (W-1, H-1)
module clear_scan #(
  parameter  int W  = 160,
  parameter  int H  = 120,
  localparam int XW = $clog2(W),
  localparam int YW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] scan_x,
  output logic [YW-1:0] scan_y,
  output logic          last
);

  logic y_wrap;
  logic x_wrap;

  assign y_wrap = (scan_y == YW'(H - 1));
  assign x_wrap = (scan_x == XW'(W - 1));
  assign last   = y_wrap && x_wrap;

  // Counter update; the wrap past the final pixel returns to (0,0) so the
  // scanner is already parked at the origin for the next run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (en) begin
      if (y_wrap) begin
        scan_y <= '0;
        scan_x <= x_wrap ? '0 : scan_x + 1'b1;
      end else begin
        scan_y <= scan_y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scene_ctrl.sv
// scene_ctrl
// Sequences one scene: clear the whole screen to CLEAR_COLOUR, then hand the
// VGA write port to the shape drawer until it reports completion.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   start                       level request, held high for a whole run
//   done                        high while the run is complete
//   colour, centre_x, centre_y,
//   diameter                    shape parameters, captured when a run starts
//   bus (scene_ctrl_if.master)  drawer control/pixel stream and VGA write port
module scene_ctrl
  import scene_pkg::*;
#(
  parameter int         SCREEN_W     = SCREEN_W_DEF,
  parameter int         SCREEN_H     = SCREEN_H_DEF,
  parameter logic [2:0] CLEAR_COLOUR = CLEAR_COLOUR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  input  logic [2:0]         colour,
  input  logic [7:0]         centre_x,
  input  logic [6:0]         centre_y,
  input  logic [7:0]         diameter,
  scene_ctrl_if.master       bus
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);

  state_t state_q;
  state_t state_d;

  logic          scan_clr;
  logic          scan_en;
  logic          scan_last;
  logic [XW-1:0] scan_x;
  logic [YW-1:0] scan_y;
  logic          capture;

  logic [2:0] colour_q;
  logic [7:0] centre_x_q;
  logic [6:0] centre_y_q;
  logic [7:0] diameter_q;

  clear_scan #(
    .W(SCREEN_W),
    .H(SCREEN_H)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .clr    (scan_clr),
    .en     (scan_en),
    .scan_x (scan_x),
    .scan_y (scan_y),
    .last   (scan_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Dropping start in any active state abandons the run;
  // the scan only advances while a clear is actually in progress.
  always_comb begin
    state_d  = state_q;
    scan_clr = 1'b0;
    scan_en  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          scan_clr = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          scan_en = 1'b1;
          if (scan_last) begin
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        if (!start) begin
          state_d = IDLE;
        end else if (bus.shape_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shape parameters are latched once per run so the drawer sees stable
  // values even if the inputs wander while the screen is being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_q   <= '0;
      centre_x_q <= '0;
      centre_y_q <= '0;
      diameter_q <= '0;
    end else if (capture) begin
      colour_q   <= colour;
      centre_x_q <= centre_x;
      centre_y_q <= centre_y;
      diameter_q <= diameter;
    end
  end

  assign bus.shape_colour   = colour_q;
  assign bus.shape_centre_x = centre_x_q;
  assign bus.shape_centre_y = centre_y_q;
  assign bus.shape_diameter = diameter_q;

  // Output mux. The drawer is released from reset only after the clear, so
  // it starts from parameters that have been stable for the whole clear.
  always_comb begin
    done            = 1'b0;
    bus.shape_rst_n = 1'b0;
    bus.shape_start = 1'b0;
    bus.vga_x       = '0;
    bus.vga_y       = '0;
    bus.vga_colour  = CLEAR_COLOUR;
    bus.vga_plot    = 1'b0;
    case (state_q)
      CLEAR: begin
        bus.vga_x    = 8'(scan_x);
        bus.vga_y    = 7'(scan_y);
        bus.vga_plot = 1'b1;
      end
      DRAW: begin
        bus.shape_rst_n = 1'b1;
        bus.shape_start = 1'b1;
        bus.vga_x       = bus.shape_x;
        bus.vga_y       = bus.shape_y;
        bus.vga_colour  = bus.shape_vga_colour;
        bus.vga_plot    = bus.shape_plot & ~bus.shape_done;
      end
      DONE: begin
        done            = 1'b1;
        bus.shape_rst_n = 1'b1;
        bus.shape_start = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scene_ctrl.sv
// tb_scene_ctrl
// Self-checking bench for scene_ctrl: directed runs (full clear, pass-through
// table, completion, abort, capture, reset mid-draw) plus randomized runs,
// every cycle compared against a run-level reference model.
module tb_scene_ctrl;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int NPIX = W * H;

  localparam int PH_IDLE  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_DRAW  = 2;
  localparam int PH_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       done;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] diameter;

  scene_ctrl_if bus ();

  scene_ctrl #(
    .SCREEN_W     (W),
    .SCREEN_H     (H),
    .CLEAR_COLOUR (3'b000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .done     (done),
    .colour   (colour),
    .centre_x (centre_x),
    .centre_y (centre_y),
    .diameter (diameter),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: which part of the run we are in and how many pixels of
  // the clear have already been written.
  int         m_phase = PH_IDLE;
  int         m_pix   = 0;
  logic [2:0] m_col   = '0;
  logic [7:0] m_cx    = '0;
  logic [6:0] m_cy    = '0;
  logic [7:0] m_d     = '0;

  int   plot_cnt;
  int   first_x, first_y, second_x, second_y, last_x, last_y;

  typedef struct {
    logic [7:0] sx;
    logic [6:0] sy;
    logic [2:0] sc;
    logic       sp;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       ep;
  } draw_vec_t;

  draw_vec_t vecs [5];

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic modelUpdate();
    if (rst) begin
      m_phase = PH_IDLE;
      m_pix   = 0;
      m_col   = '0;
      m_cx    = '0;
      m_cy    = '0;
      m_d     = '0;
    end else begin
      case (m_phase)
        PH_IDLE: if (start) begin
          m_phase = PH_CLEAR;
          m_pix   = 0;
          m_col   = colour;
          m_cx    = centre_x;
          m_cy    = centre_y;
          m_d     = diameter;
        end
        PH_CLEAR: begin
          if (!start)               m_phase = PH_IDLE;
          else if (m_pix == NPIX-1) m_phase = PH_DRAW;
          else                      m_pix   = m_pix + 1;
        end
        PH_DRAW: begin
          if (!start)                m_phase = PH_IDLE;
          else if (bus.shape_done)   m_phase = PH_DONE;
        end
        default: if (!start) m_phase = PH_IDLE;
      endcase
    end
  endtask

  function automatic logic [47:0] expectedVec();
    logic       e_done, e_srn, e_sst, e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    e_done = (m_phase == PH_DONE);
    e_srn  = (m_phase == PH_DRAW) || (m_phase == PH_DONE);
    e_sst  = e_srn;
    e_plot = 1'b0;
    e_x    = '0;
    e_y    = '0;
    e_c    = 3'b000;
    if (m_phase == PH_CLEAR) begin
      e_plot = 1'b1;
      e_x    = 8'(m_pix / H);
      e_y    = 7'(m_pix % H);
    end else if (m_phase == PH_DRAW) begin
      e_plot = bus.shape_plot & ~bus.shape_done;
      e_x    = bus.shape_x;
      e_y    = bus.shape_y;
      e_c    = bus.shape_vga_colour;
    end
    return {e_done, e_srn, e_sst, e_plot, e_x, e_y, e_c, m_col, m_cx, m_cy, m_d};
  endfunction

  function automatic logic [47:0] actualVec();
    return {done, bus.shape_rst_n, bus.shape_start, bus.vga_plot, bus.vga_x,
            bus.vga_y, bus.vga_colour, bus.shape_colour, bus.shape_centre_x,
            bus.shape_centre_y, bus.shape_diameter};
  endfunction

  task automatic cycle();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Full-output comparison against the model, plus clear-plot bookkeeping.
  task automatic checkOutput(input string name);
    logic [47:0] act, exp;
    #1;
    act = actualVec();
    exp = expectedVec();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s @%0t: got %h expected %h (phase %0d pix %0d)",
               name, $time, act, exp, m_phase, m_pix);
    end
    if (bus.vga_plot === 1'b1 && m_phase == PH_CLEAR) begin
      if (plot_cnt == 0) begin first_x = bus.vga_x; first_y = bus.vga_y; end
      if (plot_cnt == 1) begin second_x = bus.vga_x; second_y = bus.vga_y; end
      last_x = bus.vga_x;
      last_y = bus.vga_y;
      plot_cnt++;
    end
  endtask

  task automatic randomStub(input bit allow_done);
    bus.shape_x          = 8'($urandom);
    bus.shape_y          = 7'($urandom);
    bus.shape_vga_colour = 3'($urandom);
    bus.shape_plot       = 1'($urandom);
    bus.shape_done       = allow_done ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic [7:0] x,
                               input logic [6:0] y, input logic [7:0] d);
    colour   = c;
    centre_x = x;
    centre_y = y;
    diameter = d;
    start    = 1'b1;
  endtask

  // Clock through a clear until the model enters DRAW, bounded by a budget.
  task automatic runClearToDraw(input string name, input bit change_params);
    int guard;
    guard = 0;
    while (m_phase != PH_DRAW && guard < NPIX + 10) begin
      cycle();
      if (change_params && guard == 200) begin
        diameter = 8'd20;
        colour   = 3'b010;
        centre_x = 8'd5;
      end
      randomStub(1'b0);
      checkOutput(name);
      guard++;
    end
    checkValue({name, "_reached_draw"}, bus.shape_rst_n, 1);
  endtask

  initial begin
    vecs[0] = '{8'd80,  7'd60,  3'b010, 1'b1, 8'd80,  7'd60,  3'b010, 1'b1};
    vecs[1] = '{8'd80,  7'd60,  3'b010, 1'b0, 8'd80,  7'd60,  3'b010, 1'b0};
    vecs[2] = '{8'd0,   7'd0,   3'b111, 1'b1, 8'd0,   7'd0,   3'b111, 1'b1};
    vecs[3] = '{8'd159, 7'd119, 3'b001, 1'b1, 8'd159, 7'd119, 3'b001, 1'b1};
    vecs[4] = '{8'd255, 7'd127, 3'b100, 1'b1, 8'd255, 7'd127, 3'b100, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    colour = '0; centre_x = '0; centre_y = '0; diameter = '0;
    bus.shape_done = 1'b0; bus.shape_x = '0; bus.shape_y = '0;
    bus.shape_vga_colour = '0; bus.shape_plot = 1'b0;
    plot_cnt = 0;
    first_x = -1; first_y = -1; second_x = -1; second_y = -1;
    last_x = -1; last_y = -1;

    // Reset for two cycles.
    for (int i = 0; i < 2; i++) begin
      cycle();
      checkOutput("reset_hold");
    end
    checkValue("reset_done", done, 0);
    checkValue("reset_plot", bus.vga_plot, 0);
    checkValue("reset_shape_start", bus.shape_start, 0);
    checkValue("reset_shape_rst_n", bus.shape_rst_n, 0);
    rst = 1'b0;

    // Full clear, with parameters changed partway through.
    applyStimulus(3'b101, 8'd80, 7'd60, 8'd80);
    checkOutput("idle_before_start");
    plot_cnt = 0;
    runClearToDraw("clear_run", 1'b1);
    checkValue("clear_plot_count", plot_cnt, NPIX);
    checkValue("clear_first_x", first_x, 0);
    checkValue("clear_first_y", first_y, 0);
    checkValue("clear_second_x", second_x, 0);
    checkValue("clear_second_y", second_y, 1);
    checkValue("clear_last_x", last_x, W - 1);
    checkValue("clear_last_y", last_y, H - 1);
    checkValue("draw_shape_start", bus.shape_start, 1);
    checkValue("draw_diameter_held", bus.shape_diameter, 80);

    // Drawer pass-through vectors.
    for (int i = 0; i < 5; i++) begin
      cycle();
      bus.shape_done       = 1'b0;
      bus.shape_x          = vecs[i].sx;
      bus.shape_y          = vecs[i].sy;
      bus.shape_vga_colour = vecs[i].sc;
      bus.shape_plot       = vecs[i].sp;
      checkOutput("draw_vec");
      checkValue($sformatf("draw_vec%0d_x", i), bus.vga_x, vecs[i].ex);
      checkValue($sformatf("draw_vec%0d_y", i), bus.vga_y, vecs[i].ey);
      checkValue($sformatf("draw_vec%0d_c", i), bus.vga_colour, vecs[i].ec);
      checkValue($sformatf("draw_vec%0d_p", i), bus.vga_plot, vecs[i].ep);
    end

    // Completion and release.
    cycle();
    bus.shape_done = 1'b1;
    bus.shape_plot = 1'b1;
    checkOutput("shape_done_cycle");
    checkValue("shape_done_plot_masked", bus.vga_plot, 0);
    cycle();
    checkOutput("done_state");
    checkValue("done_high", done, 1);
    checkValue("done_plot", bus.vga_plot, 0);
    checkValue("done_diameter_held", bus.shape_diameter, 80);
    cycle();
    start = 1'b0;
    checkOutput("done_start_low");
    checkValue("done_still_high", done, 1);
    cycle();
    checkOutput("back_to_idle");
    checkValue("idle_done_low", done, 0);
    checkValue("idle_shape_rst_n", bus.shape_rst_n, 0);

    // Abort partway through a clear, then restart.
    bus.shape_done = 1'b0;
    applyStimulus(3'b011, 8'd10, 7'd20, 8'd33);
    checkOutput("abort_start");
    begin
      int guard;
      guard = 0;
      while (!(m_phase == PH_CLEAR && m_pix == 37 * H + 5) && guard < 6000) begin
        cycle();
        randomStub(1'b0);
        checkOutput("abort_scan");
        guard++;
      end
    end
    checkValue("abort_at_x", bus.vga_x, 37);
    checkValue("abort_at_y", bus.vga_y, 5);
    start = 1'b0;
    cycle();
    checkOutput("abort_idle");
    checkValue("abort_plot_low", bus.vga_plot, 0);
    start = 1'b1;
    cycle();
    checkOutput("restart_first");
    checkValue("restart_x", bus.vga_x, 0);
    checkValue("restart_y", bus.vga_y, 0);
    checkValue("restart_plot", bus.vga_plot, 1);

    // Finish the clear, draw a while, then reset mid-draw.
    runClearToDraw("clear_run2", 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle();
      randomStub(1'b0);
      checkOutput("draw_random");
    end
    rst = 1'b1;
    bus.shape_plot = 1'b1;
    cycle();
    checkOutput("reset_mid_draw");
    checkValue("rst_draw_done", done, 0);
    checkValue("rst_draw_plot", bus.vga_plot, 0);
    checkValue("rst_draw_shape_rst_n", bus.shape_rst_n, 0);
    checkValue("rst_draw_shape_start", bus.shape_start, 0);
    rst = 1'b0;
    start = 1'b0;
    cycle();
    checkOutput("after_reset_idle");

    // Randomized short runs with random aborts, drawer noise and resets.
    for (int r = 0; r < 12; r++) begin
      int len;
      applyStimulus(3'($urandom), 8'($urandom), 7'($urandom), 8'($urandom));
      len = $urandom_range(1, 600);
      for (int c = 0; c < len; c++) begin
        cycle();
        randomStub(1'b1);
        colour   = 3'($urandom);
        diameter = 8'($urandom);
        rst      = ($urandom_range(0, 199) == 0);
        checkOutput("random_run");
      end
      rst   = 1'b0;
      start = 1'b0;
      cycle();
      checkOutput("random_end");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
